// File: rtl/vga_clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_clock_pkg
// Purpose  : Widths, window defaults and the default 3x5 digit font shared by
//            the VGA clock pixel pipeline and its timing generator.
// Revision : 1.0 - initial release
// ============================================================================
package vga_clock_pkg;

  localparam int RGB_W        = 6;
  localparam int BLOCK_W      = 6;
  localparam int PX_W         = 10;
  localparam int FONT_ENTRIES = 64;
  localparam int FONT_ROW_MAX = 16;
  localparam int FONT_ROW_W   = 4;

  localparam int X_ORIGIN_DEF   = 32;
  localparam int Y_ORIGIN_DEF   = 160;
  localparam int BLOCK_PX_DEF   = 16;
  localparam int NUM_BLOCKS_DEF = 20;
  localparam int FONT_H_DEF     = 5;
  localparam int X_WIN_END_DEF  = X_ORIGIN_DEF + NUM_BLOCKS_DEF * BLOCK_PX_DEF;
  localparam int Y_WIN_END_DEF  = Y_ORIGIN_DEF + FONT_H_DEF * BLOCK_PX_DEF;

  typedef logic [RGB_W-1:0] rgb_t;

  // Font image: entry a occupies bits [a*16 +: 16]; bit r of an entry = row r lit.
  typedef logic [FONT_ENTRIES*FONT_ROW_MAX-1:0] font_image_t;

  typedef struct packed {
    logic                  win;
    logic [FONT_ROW_W-1:0] row;
  } stage1_t;

  // Digits 0..9, three columns each, glyph base = 3*digit.
  localparam logic [4:0] DIGIT_COLS [30] = '{
    5'b11111, 5'b10001, 5'b11111,
    5'b00000, 5'b11111, 5'b00000,
    5'b11101, 5'b10101, 5'b10111,
    5'b10101, 5'b10101, 5'b11111,
    5'b00111, 5'b00100, 5'b11111,
    5'b10111, 5'b10101, 5'b11101,
    5'b11111, 5'b10101, 5'b11101,
    5'b00001, 5'b00001, 5'b11111,
    5'b11111, 5'b10101, 5'b11111,
    5'b10111, 5'b10101, 5'b11111
  };

  function automatic font_image_t digit_font();
    font_image_t img;
    img = '0;
    for (int i = 0; i < 30; i++) begin
      img[i*FONT_ROW_MAX +: 5] = DIGIT_COLS[i];
    end
    return img;
  endfunction

endpackage
`default_nettype wire

// File: rtl/digit_scan_render_if.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_render_if
// Purpose  : Block-coordinate / glyph-lookup bus between the pixel renderer
//            (master) and the per-digit lookup stage (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface digit_scan_render_if
  import vga_clock_pkg::*;
#(
  parameter int FONT_W = 3
);
  localparam int COL_W = (FONT_W > 1) ? $clog2(FONT_W) : 1;

  logic [BLOCK_W-1:0] x_block;
  logic [BLOCK_W-1:0] y_block;
  logic [5:0]         digit_index;
  logic [COL_W-1:0]   col_index;
  logic [RGB_W-1:0]   color;

  modport master (output x_block, y_block, input digit_index, col_index, color);
  modport slave  (input x_block, y_block, output digit_index, col_index, color);

endinterface
`default_nettype wire

// File: rtl/digit_scan_render_font_rom.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_render_font_rom
// Purpose  : 64-entry font column ROM with a registered single-bit row read.
// Revision : 1.0 - initial release
// ============================================================================
module digit_scan_render_font_rom
  import vga_clock_pkg::*;
#(
  parameter font_image_t FONT_INIT = digit_font()
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            addr,
  input  logic [FONT_ROW_W-1:0] row,
  output logic                  lit
);

  logic [9:0]              w_base;
  logic [FONT_ROW_MAX-1:0] w_entry;
  logic                    r_lit;

  assign w_base  = {addr, 4'b0000};
  assign w_entry = FONT_INIT[w_base +: FONT_ROW_MAX];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lit <= 1'b0;
    end else begin
      r_lit <= w_entry[row];
    end
  end

  assign lit = r_lit;

endmodule
`default_nettype wire

// File: rtl/digit_scan_render.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_render
// Purpose  : Pixel coordinates -> block coordinates -> font lookup -> RGB,
//            fixed 3-cycle latency from x_px/y_px to rgb.
// Revision : 1.0 - initial release
// ============================================================================
module digit_scan_render
  import vga_clock_pkg::*;
#(
  parameter font_image_t FONT_INIT  = digit_font(),
  parameter int          FONT_W     = 3,
  parameter int          FONT_H     = FONT_H_DEF,
  parameter int          BLOCK_PX   = BLOCK_PX_DEF,
  parameter int          NUM_BLOCKS = NUM_BLOCKS_DEF,
  parameter int          X_ORIGIN   = X_ORIGIN_DEF,
  parameter int          Y_ORIGIN   = Y_ORIGIN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PX_W-1:0]      x_px,
  input  logic [PX_W-1:0]      y_px,
  input  logic                 activevideo,
  digit_scan_render_if.master  lk,
  output logic [RGB_W-1:0]     rgb
);

  localparam int CNT_W = $clog2(BLOCK_PX);
  localparam int COL_W = (FONT_W > 1) ? $clog2(FONT_W) : 1;

  localparam logic [PX_W-1:0]    c_x_lo     = PX_W'(X_ORIGIN);
  localparam logic [PX_W-1:0]    c_x_hi     = PX_W'(X_ORIGIN + NUM_BLOCKS * BLOCK_PX);
  localparam logic [PX_W-1:0]    c_y_lo     = PX_W'(Y_ORIGIN);
  localparam logic [PX_W-1:0]    c_y_hi     = PX_W'(Y_ORIGIN + FONT_H * BLOCK_PX);
  localparam logic [PX_W-1:0]    c_y_prev   = PX_W'(Y_ORIGIN - 1);
  localparam logic [CNT_W-1:0]   c_px_last  = CNT_W'(BLOCK_PX - 1);
  localparam logic [BLOCK_W-1:0] c_x_last   = BLOCK_W'(NUM_BLOCKS - 1);
  localparam logic [BLOCK_W-1:0] c_y_last   = BLOCK_W'(FONT_H - 1);

  logic               w_in_x, w_y_range, w_in_y, w_av_fall, w_x_origin;
  logic [5:0]         w_addr;
  logic               w_lit2;

  logic [CNT_W-1:0]   r_px_cnt, r_row_cnt;
  logic [BLOCK_W-1:0] r_x_block, r_y_block;
  logic               r_x_run, r_y_run, r_av_d, r_win0;
  stage1_t            r_s1;
  logic               r_win2;
  rgb_t               r_col2, r_rgb;

  always_comb begin
    w_x_origin = (x_px == c_x_lo);
    w_in_x     = activevideo && (x_px >= c_x_lo) && (x_px < c_x_hi);
    w_y_range  = (y_px >= c_y_lo) && (y_px < c_y_hi);
    w_in_y     = activevideo && w_y_range;
    w_av_fall  = r_av_d && !activevideo;
  end

  // Stage 0: block counters. The run flags keep the window dark after a
  // reset until the counters have been re-aligned at a window entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_px_cnt  <= '0;
      r_row_cnt <= '0;
      r_x_block <= '0;
      r_y_block <= '0;
      r_x_run   <= 1'b0;
      r_y_run   <= 1'b0;
      r_av_d    <= 1'b0;
      r_win0    <= 1'b0;
    end else begin
      r_av_d <= activevideo;
      if (w_x_origin) begin
        r_px_cnt  <= CNT_W'(1);
        r_x_block <= '0;
        r_x_run   <= 1'b1;
      end else if (w_in_x) begin
        r_px_cnt <= (r_px_cnt == c_px_last) ? '0 : r_px_cnt + CNT_W'(1);
        // Step on the pixel after the wrap so block k starts at X_ORIGIN + k*BLOCK_PX.
        if (r_px_cnt == '0 && r_x_block != c_x_last) begin
          r_x_block <= r_x_block + BLOCK_W'(1);
        end
      end
      if (w_av_fall) begin
        if (y_px == c_y_prev || (y_px == c_y_lo && !r_y_run)) begin
          r_row_cnt <= '0;
          r_y_block <= '0;
          r_y_run   <= 1'b1;
        end else if (r_y_run && w_y_range) begin
          if (r_row_cnt == c_px_last) begin
            r_row_cnt <= '0;
            if (r_y_block != c_y_last) begin
              r_y_block <= r_y_block + BLOCK_W'(1);
            end
          end else begin
            r_row_cnt <= r_row_cnt + CNT_W'(1);
          end
        end
      end
      r_win0 <= w_in_x && w_in_y && r_y_run && (w_x_origin || r_x_run);
    end
  end

  assign lk.x_block = r_x_block;
  assign lk.y_block = r_y_block;

  // Stages 1..3: lookup stage answers alongside stage 1, ROM read in stage 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1   <= '0;
      r_win2 <= 1'b0;
      r_col2 <= '0;
      r_rgb  <= '0;
    end else begin
      r_s1.win <= r_win0;
      r_s1.row <= r_y_block[FONT_ROW_W-1:0];
      r_win2   <= r_s1.win;
      r_col2   <= lk.color;
      r_rgb    <= (r_win2 && w_lit2) ? r_col2 : '0;
    end
  end

  assign w_addr = lk.digit_index + {{(6-COL_W){1'b0}}, lk.col_index};

  digit_scan_render_font_rom #(
    .FONT_INIT (FONT_INIT)
  ) u_font_rom (
    .clk   (clk),
    .reset (reset),
    .addr  (w_addr),
    .row   (r_s1.row),
    .lit   (w_lit2)
  );

  assign rgb = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_render.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_scan_render
// Purpose  : Directed scoreboard bench for the digit pixel renderer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_scan_render;
  import vga_clock_pkg::*;

  function automatic font_image_t make_font();
    font_image_t f;
    f = '0;
    for (int a = 0; a < 64; a++) f[a*16 +: 16] = 16'((a * 7 + 3) & 31);
    f[5*16 +: 16] = 16'hFFE0 | 16'b10101;
    f[1*16 +: 16] = 16'b11010;
    return f;
  endfunction

  localparam font_image_t TB_FONT = make_font();

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] x_px = '0;
  logic [9:0] y_px = '0;
  logic       activevideo = 1'b0;
  logic [5:0] rgb;
  logic [5:0] cfg_dig = '0;
  logic [1:0] cfg_col = '0;
  logic [5:0] cfg_color = '0;

  int         ntests = 0;
  int         nfail = 0;
  logic [5:0] sb[$];
  bit         prev_av = 0, prev_rst = 0, started = 0, xrun = 0, chk_x = 0;
  int         prev_x = 0;

  always #5 clk = ~clk;

  digit_scan_render_if #(.FONT_W(3)) lk ();
  assign lk.digit_index = cfg_dig;
  assign lk.col_index   = cfg_col;
  assign lk.color       = cfg_color;

  digit_scan_render #(
    .FONT_INIT(TB_FONT), .FONT_W(3), .FONT_H(5), .BLOCK_PX(16),
    .NUM_BLOCKS(20), .X_ORIGIN(32), .Y_ORIGIN(160)
  ) dut (
    .clk(clk), .reset(reset), .x_px(x_px), .y_px(y_px),
    .activevideo(activevideo), .lk(lk), .rgb(rgb)
  );

  task automatic check6(input string tag, input logic [5:0] got, input logic [5:0] exp);
    ntests++;
    assert (got === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] expect_rgb(input int x, input int y, input bit av);
    int          row;
    int          ai;
    logic [15:0] e;
    if (!(av && started && xrun && x >= 32 && x < 352 && y >= 160 && y < 240)) return 6'd0;
    row = (y - 160) / 16;
    ai  = int'(6'(cfg_dig + 6'(cfg_col)));
    e   = TB_FONT[ai*16 +: 16];
    return e[row] ? cfg_color : 6'd0;
  endfunction

  function automatic logic [5:0] exp_yb(input int y);
    int v;
    v = (y - 159) / 16;
    return 6'((v > 4) ? 4 : v);
  endfunction

  task automatic step(input int x, input int y, input bit av, input bit rst_in);
    logic [5:0] e;
    int         xb;
    @(negedge clk);
    if (sb.size() >= 4) begin
      e = sb.pop_front();
      check6("rgb", rgb, e);
    end
    if (prev_rst) begin
      check6("reset_rgb", rgb, 6'd0);
      check6("reset_x_block", lk.x_block, 6'd0);
      check6("reset_y_block", lk.y_block, 6'd0);
    end
    if (chk_x && prev_x >= 32) begin
      xb = (prev_x - 32) / 16;
      check6("x_block", lk.x_block, 6'((xb > 19) ? 19 : xb));
    end
    if (rst_in) begin
      foreach (sb[i]) sb[i] = 6'd0;
      started = 0;
      xrun    = 0;
    end else if (x == 32) begin
      xrun = 1;
    end
    reset       = rst_in;
    x_px        = 10'(x);
    y_px        = 10'(y);
    activevideo = av;
    sb.push_back(rst_in ? 6'd0 : expect_rgb(x, y, av));
    if (!rst_in && !av && prev_av && y == 159) started = 1;
    prev_av  = rst_in ? 1'b0 : av;
    prev_x   = x;
    prev_rst = rst_in;
  endtask

  // Shortened line: window entry, right edge, then blanking with a falling activevideo.
  task automatic line(input int y, input bit chk_y);
    for (int x = 28; x <= 40; x++) step(x, y, 1'b1, 1'b0);
    for (int x = 346; x <= 356; x++) step(x, y, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(640 + i, y, 1'b0, 1'b0);
    if (chk_y) check6("y_block", lk.y_block, exp_yb(y));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b1);

    cfg_dig = 6'h04; cfg_col = 2'd1; cfg_color = 6'b110000;
    line(159, 1'b1);

    // Full scan line with x_block tracking.
    step(0, 160, 1'b1, 1'b0);
    chk_x = 1;
    for (int x = 1; x < 800; x++) step(x, 160, x < 640, 1'b0);
    chk_x = 0;
    check6("y_block_160", lk.y_block, exp_yb(160));

    for (int y = 161; y <= 245; y++) line(y, 1'b1);

    // activevideo dropped while coordinates are inside the window.
    line(159, 1'b1);
    for (int x = 28; x <= 60; x++) step(x, 160, !(x >= 40 && x <= 44), 1'b0);
    for (int i = 0; i < 4; i++) step(640 + i, 160, 1'b0, 1'b0);

    // Address wrap: 0x3F + 2 -> entry 1.
    cfg_dig = 6'h3F; cfg_col = 2'd2; cfg_color = 6'b001011;
    line(159, 1'b1);
    for (int y = 160; y <= 180; y++) line(y, 1'b1);

    // Reset mid-line with the window active, then a clean restart.
    for (int x = 28; x <= 40; x++) step(x, 181, 1'b1, 1'b0);
    for (int x = 41; x <= 43; x++) step(x, 181, 1'b1, 1'b1);
    for (int x = 44; x <= 60; x++) step(x, 181, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(640 + i, 181, 1'b0, 1'b0);
    line(182, 1'b0);
    cfg_dig = 6'h04; cfg_col = 2'd1; cfg_color = 6'b110000;
    line(159, 1'b1);
    line(160, 1'b1);
    for (int i = 0; i < 4; i++) step(700, 161, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/digit_scan_render.md
Name: digit_scan_render

Overview:
- Pixel-side counterpart of the per-digit lookup stage in the VGA clock.
- Turns raw VGA pixel coordinates into block coordinates (x_block/y_block) and drives them to the lookup stage.
- Receives that stage's registered digit_index/col_index/color one cycle later and reads the font column ROM.
- Emits a 6-bit RGB pixel aligned to a fixed, documented latency; sits between the VGA timing generator and the output pins.

Parameters:
FONT_FILE, "font.hex", $readmemb image of font columns, 64 entries x FONT_H bits, bit r = row r lit
FONT_W, 3, font columns per glyph (informational; col_index width = $clog2(FONT_W))
FONT_H, 5, glyph rows = number of block rows drawn
BLOCK_PX, 16, screen pixels per block edge (2..64)
NUM_BLOCKS, 20, block columns in the drawing window
X_ORIGIN, 32, first pixel column of window
Y_ORIGIN, 160, first pixel row of window

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
x_px  in  10  current pixel column from timing generator
y_px  in  10  current pixel row from timing generator
activevideo  in  1  high while x_px/y_px are visible
x_block  out  6  block column to lookup stage (registered)
y_block  out  6  block row (registered)
digit_index  in  6  glyph base address, valid 1 cycle after x_block
col_index  in  $clog2(FONT_W)  column offset, same timing
color  in  6  RRGGBB, same timing
rgb  out  6  pixel colour, RRGGBB

Behaviour:
- One clock domain. Reset is synchronous, active-high, and applied on clk edge. All outputs, counters and pipeline flags clear to 0. Reset mid-frame: rgb is 0 from the next edge; drawing restarts cleanly from the next window entry.
- Stage 0, block counters, registered:
  - in_x = activevideo && x_px >= X_ORIGIN && x_px < X_ORIGIN+NUM_BLOCKS*BLOCK_PX; in_y is the analogue on y_px with FONT_H*BLOCK_PX.
  - x_px == X_ORIGIN: px_cnt <= 1 (or 0 if BLOCK_PX==1, excluded by parameter range), x_block <= 0.
  - Else if in_x: px_cnt increments; on px_cnt == BLOCK_PX-1 it wraps to 0 and x_block increments.
  - x_block saturates at NUM_BLOCKS-1. Never wraps past 63.
  - Line counting: on falling edge of activevideo (registered copy of activevideo used for edge detection):
    - if y_px == Y_ORIGIN-1, or on the first line where y_px == Y_ORIGIN: row_cnt <= 0, y_block <= 0;
    - else if inside the vertical window: row_cnt increments, wraps at BLOCK_PX-1, and y_block increments, saturating at FONT_H-1.
  - win0 = in_x && in_y is registered alongside x_block/y_block.
- Stage 1: lookup stage responds; win1 <= win0, row1 <= y_block.
- Stage 2:
  - addr = digit_index + col_index, 6-bit, wraps mod 64.
  - lit2 <= font_mem[addr][row1].
  - win2 <= win1; col2 <= color.
- Stage 3: rgb <= (win2 && lit2) ? col2 : 6'b0.
- Latency: x_px/y_px/activevideo at cycle N -> rgb at edge N+3. Horizontal placement is therefore shifted right 3 pixels; the timing generator compensates. This latency is fixed and must not change.
- Outside the window, or with activevideo low, rgb is 0 regardless of lookup inputs.
- row1 >= FONT_H cannot occur (saturation); ROM bits above FONT_H-1 are ignored.
- No handshake: strictly streaming, one pixel per clock, no stalls.

Decomposition:
- Shared package vga_clock_pkg holds:
  - RGB_W=6
  - BLOCK_W=6
  - PX_W=10
  - localparams for window extents used here and by the timing generator
- One natural sub-module: font_rom (synchronous-read 64 x FONT_H memory loaded from FONT_FILE, 1-cycle read). Stage 2 instantiates it.
- Block counters stay inline.

Test Plan:
- Reset held 3 cycles mid-line with window active -> rgb, x_block, y_block all 0 on every edge during reset; first non-zero rgb only after next window entry + 3.
- Scan line y_px=160, x_px 0..799, activevideo high for 0..639, BLOCK_PX=16 -> x_block stays 0 through x_px=47, becomes 1 at register edge after x_px=48, saturates at 19 from x_px=336 onward.
- Behavioural lookup model returns digit_index=6'h04, col_index=1, color=6'b110000; FONT_FILE entry 5 = 5'b10101; y_block=2 -> rgb=6'b110000 exactly 3 cycles after each in-window pixel; y_block=1 -> rgb=0.
- Full frame 640x480: y_block increments after lines 175, 191, 207, 223, then holds at 4; lines >=240 give rgb=0 throughout.
- activevideo low while x_px/y_px in window -> rgb=0 three cycles later.
- digit_index=6'h3F, col_index=2 -> ROM address wraps to 1; rgb follows entry 1.
